// File: rtl/wb_io_output_pkg.sv
// rtl/wb_io_output_pkg.sv - shared constants for the WB-stage LED / 7-segment sink
package wb_io_output_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low cathode patterns {dp,g,f,e,d,c,b,a} for hex digits 0..F, dp kept off
  localparam logic [7:0] SEG_PATTERNS [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic int prescWidth(input int scanDiv);
    return (scanDiv < 2) ? 1 : $clog2(scanDiv);
  endfunction

endpackage

// File: rtl/wb_io_output_hex7seg.sv
// rtl/wb_io_output_hex7seg.sv - combinational nibble to active-low 7-segment pattern
module hex7seg
  import wb_io_output_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] pattern
);

  assign pattern = SEG_PATTERNS[nibble];

endmodule

// File: rtl/wb_io_output.sv
// rtl/wb_io_output.sv - WB-stage IO sink driving board LEDs and an 8-digit multiplexed display
module wb_io_output
  import wb_io_output_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int LED_W    = 16,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             WB_ioWrite,
  input  logic             WB_SegCtrl,
  input  logic             WB_LEDCtrl,
  input  logic [31:0]      io_wdata,
  output logic [LED_W-1:0] led,
  output logic [7:0]       seg_an,
  output logic [7:0]       seg_cat
);

  localparam int                 PRESC_W    = prescWidth(SCAN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

  logic [31:0]        dispReg;
  logic [PRESC_W-1:0] presc;
  logic [2:0]         digIdx;
  logic               ledWe;
  logic               segWe;
  logic [3:0]         digNibble;
  logic [7:0]         digPattern;
  logic [31:0]        dispUpper;
  logic               digBlank;

  assign ledWe = WB_ioWrite & WB_LEDCtrl;
  assign segWe = WB_ioWrite & WB_SegCtrl;

  assign digNibble = dispReg[{digIdx, 2'b00} +: 4];

  // A digit is a leading zero when it and every nibble above it are zero; digit 0 always shows
  assign dispUpper = dispReg >> {digIdx, 2'b00};
  assign digBlank  = BLANK_LZ && (digIdx != 3'd0) && (dispUpper == 32'd0);

  hex7seg uDecode (
    .nibble  (digNibble),
    .pattern (digPattern)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      led     <= '0;
      dispReg <= '0;
      presc   <= '0;
      digIdx  <= '0;
      seg_an  <= SEG_OFF;
      seg_cat <= SEG_OFF;
    end else begin
      if (ledWe) begin
        led <= io_wdata[LED_W-1:0];
      end
      if (segWe) begin
        dispReg <= io_wdata;
      end

      if (presc == PRESC_LAST) begin
        presc  <= '0;
        digIdx <= digIdx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end

      seg_an  <= ~(8'b1 << digIdx);
      seg_cat <= digBlank ? SEG_OFF : digPattern;
    end
  end

endmodule

// File: tb/tb_wb_io_output.sv
// tb/tb_wb_io_output.sv - scoreboard bench for wb_io_output with a 4-clock digit slot
module tb_wb_io_output;

  logic        clk = 1'b0;
  logic        rstn;
  logic        WB_ioWrite;
  logic        WB_SegCtrl;
  logic        WB_LEDCtrl;
  logic [31:0] io_wdata;
  logic [15:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  localparam int T_RESET = 0;
  localparam int T_LED   = 1;
  localparam int T_IGN   = 2;
  localparam int T_DISP  = 3;
  localparam int T_DUAL  = 4;
  localparam int T_MID   = 5;

  typedef struct {
    int          cyc;
    logic [15:0] led;
    logic [7:0]  an;
    logic [7:0]  cat;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Per-digit tables, digit 0 in the low byte
  logic [63:0] anTab    = 64'h7FBF_DFEF_F7FB_FDFE;
  logic [63:0] catZero  = 64'hFFFF_FFFF_FFFF_FFC0;
  logic [63:0] catA5    = 64'hFFFF_FFFF_FFFF_8892;
  logic [63:0] cat8765  = 64'h80F8_8292_99B0_A4F9;

  wb_io_output #(
    .SCAN_DIV (4),
    .LED_W    (16),
    .BLANK_LZ (1'b1)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .WB_ioWrite (WB_ioWrite),
    .WB_SegCtrl (WB_SegCtrl),
    .WB_LEDCtrl (WB_LEDCtrl),
    .io_wdata   (io_wdata),
    .led        (led),
    .seg_an     (seg_an),
    .seg_cat    (seg_cat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string tagName(input int t);
    case (t)
      T_RESET: return "reset";
      T_LED:   return "led_write";
      T_IGN:   return "ignored_ctrl";
      T_DISP:  return "display_blank";
      T_DUAL:  return "dual_write";
      default: return "reset_midscan";
    endcase
  endfunction

  task automatic pushExp(input int c, input logic [15:0] l, input logic [7:0] a,
                         input logic [7:0] k, input int t);
    exp_t e;
    e.cyc = c;
    e.led = l;
    e.an  = a;
    e.cat = k;
    e.tag = t;
    sb.push_back(e);
  endtask

  // rel is the last reset edge; digit d is driven on edges rel+1+4d .. rel+4+4d
  task automatic pushScan(input int fromC, input int toC, input int rel,
                          input logic [15:0] l, input logic [63:0] catTab, input int t);
    for (int c = fromC; c <= toC; c++) begin
      int d;
      d = ((c - rel - 1) / 4) % 8;
      pushExp(c, l, anTab[8*d +: 8], catTab[8*d +: 8], t);
    end
  endtask

  task automatic cmp(input string what, input int t, input int c,
                     input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s/%s cycle %0d: got %h expected %h", tagName(t), what, c, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic w, input logic s, input logic l, input logic [31:0] d);
    WB_ioWrite = w;
    WB_SegCtrl = s;
    WB_LEDCtrl = l;
    io_wdata   = d;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s/missed cycle %0d: got none expected sample", tagName(e.tag), e.cyc);
      end else begin
        cmp("led", e.tag, e.cyc, led, e.led);
        cmp("seg_an", e.tag, e.cyc, {8'h00, seg_an}, {8'h00, e.an});
        cmp("seg_cat", e.tag, e.cyc, {8'h00, seg_cat}, {8'h00, e.cat});
      end
    end
  end

  initial begin
    exp_t e;
    rstn = 1'b0;
    // A write held through reset must be discarded
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step(3);
    rstn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    pushExp(3, 16'h0, 8'hFF, 8'hFF, T_RESET);
    pushScan(4, 5, 3, 16'h0, catZero, T_RESET);
    step(2);

    drive(1'b1, 1'b0, 1'b1, 32'h1234_ABCD);
    pushExp(6, 16'hABCD, 8'hFE, 8'hC0, T_LED);
    step(1);

    drive(1'b0, 1'b1, 1'b1, 32'h0000_FFFF);
    pushScan(7, 8, 3, 16'hABCD, catZero, T_IGN);
    step(1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(1);

    drive(1'b1, 1'b1, 1'b0, 32'h0000_00A5);
    pushExp(9, 16'hABCD, 8'hFD, 8'hFF, T_DISP);
    pushScan(10, 43, 3, 16'hABCD, catA5, T_DISP);
    step(1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(34);

    drive(1'b1, 1'b1, 1'b1, 32'h8765_4321);
    pushExp(44, 16'h4321, 8'hFB, 8'hFF, T_DUAL);
    pushScan(45, 88, 3, 16'h4321, cat8765, T_DUAL);
    step(1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step(44);

    // Scan is on digit 5 here; reset with a write presented in the same cycle
    rstn = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h1234_5678);
    pushExp(89, 16'h0, 8'hFF, 8'hFF, T_MID);
    step(1);
    rstn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    pushScan(90, 101, 89, 16'h0, catZero, T_MID);
    step(12);

    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s/timeout cycle %0d: got no sample expected one", tagName(e.tag), e.cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
